// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared encodings and arithmetic helpers for the HI/LO multiply/divide unit.
// The MDUcal / MDUwrite encodings and the operation latencies are shared by
// the instruction decoder and mult_div_unit, so they live here and nowhere else.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    // MDUcal operation select
    localparam logic [3:0] MDU_SIGN_MULT = 4'd1;
    localparam logic [3:0] MDU_ZERO_MULT = 4'd2;
    localparam logic [3:0] MDU_SIGN_DIV  = 4'd3;
    localparam logic [3:0] MDU_ZERO_DIV  = 4'd4;

    // MDUwrite register move select (0 = no move)
    localparam logic [3:0] MDU_WHI       = 4'd1;
    localparam logic [3:0] MDU_WLO       = 4'd2;

    // Busy cycles after the launch edge
    localparam logic [3:0] MULT_LATENCY  = 4'd5;
    localparam logic [3:0] DIV_LATENCY   = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // True for the four operations the unit knows how to run.
    function automatic logic is_legal_cal(input logic [3:0] cal);
        return (cal >= MDU_SIGN_MULT) && (cal <= MDU_ZERO_DIV);
    endfunction

    // True for the two multiply encodings.
    function automatic logic is_mult_cal(input logic [3:0] cal);
        return (cal == MDU_SIGN_MULT) || (cal == MDU_ZERO_MULT);
    endfunction

    // Full 64-bit product, signed or unsigned.
    function automatic logic [63:0] mdu_mult(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        is_signed);
        logic [63:0] prod;
        if (is_signed) begin
            prod = $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        end else begin
            prod = {32'd0, a} * {32'd0, b};
        end
        return prod;
    endfunction

    // Returns {remainder, quotient}. Quotient truncates toward zero and the
    // remainder takes the dividend's sign. A zero divisor returns zero (the
    // caller suppresses the write), and the one signed overflow case
    // (-2^31 / -1) is pinned to quotient -2^31, remainder 0 so the result is
    // deterministic in every simulator and in silicon.
    function automatic logic [63:0] mdu_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        is_signed);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        quo;
        logic [31:0]        rem;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            quo = 32'd0;
            rem = 32'd0;
        end else if (is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end else if (is_signed) begin
            quo = $unsigned(sa / sb);
            rem = $unsigned(sa % sb);
        end else begin
            quo = a / b;
            rem = a % b;
        end
        return {rem, quo};
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// A start strobe in IDLE latches the operands and runs for a fixed 5 (mult)
// or 10 (div) cycles; the result is computed from the latched operands and
// written to HI/LO on the edge where busy falls. mthi/mtlo moves load HI/LO
// directly from A when the unit is idle.
//
// Ports
//   clk      in   1   clock, rising edge
//   reset    in   1   synchronous reset, active low
//   start    in   1   launch strobe for mult/multu/div/divu
//   MDUcal   in   4   operation select (1 mult, 2 multu, 3 div, 4 divu)
//   MDUwrite in   4   register move (1 mthi, 2 mtlo, 0 none)
//   A        in  32   rs operand
//   B        in  32   rt operand
//   Req      in   1   exception/interrupt: blocks this cycle's start/move
//   busy     out  1   operation in flight (registered)
//   HI       out 32   HI register
//   LO       out 32   LO register
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUcal,
    input  logic [3:0]  MDUwrite,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e  state_r;
    mdu_state_e  state_next_s;
    logic [3:0]  cnt_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [3:0]  cal_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;

    logic        launch_s;
    logic        done_s;
    logic        write_hi_s;
    logic        write_lo_s;
    logic [3:0]  launch_lat_s;
    logic [63:0] result_s;
    logic        result_we_s;

    // Next-state and control decode; moves are only honoured in IDLE with no start.
    always_comb begin
        state_next_s = state_r;
        launch_s     = 1'b0;
        done_s       = 1'b0;
        write_hi_s   = 1'b0;
        write_lo_s   = 1'b0;
        launch_lat_s = is_mult_cal(MDUcal) ? MULT_LATENCY : DIV_LATENCY;
        case (state_r)
            ST_IDLE: begin
                if (Req) begin
                    state_next_s = ST_IDLE;
                end else if (start) begin
                    // An illegal select drops the start and also swallows any move.
                    if (is_legal_cal(MDUcal)) begin
                        launch_s     = 1'b1;
                        state_next_s = ST_BUSY;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else if (MDUwrite == MDU_WHI) begin
                    write_hi_s = 1'b1;
                end else if (MDUwrite == MDU_WLO) begin
                    write_lo_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Req does not abort an operation already in flight.
                if (cnt_r == 4'd1) begin
                    done_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Result datapath from the latched operands; a zero divisor leaves HI/LO untouched.
    always_comb begin
        result_s    = {hi_r, lo_r};
        result_we_s = done_s;
        case (cal_r)
            MDU_SIGN_MULT: result_s = mdu_mult(a_r, b_r, 1'b1);
            MDU_ZERO_MULT: result_s = mdu_mult(a_r, b_r, 1'b0);
            MDU_SIGN_DIV: begin
                result_s    = mdu_div(a_r, b_r, 1'b1);
                result_we_s = done_s && (b_r != 32'd0);
            end
            MDU_ZERO_DIV: begin
                result_s    = mdu_div(a_r, b_r, 1'b0);
                result_we_s = done_s && (b_r != 32'd0);
            end
            default: begin
                result_s    = {hi_r, lo_r};
                result_we_s = 1'b0;
            end
        endcase
    end

    // State, busy flag, latency counter and operand latches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 4'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            cal_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_BUSY);
            if (launch_s) begin
                a_r   <= A;
                b_r   <= B;
                cal_r <= MDUcal;
                cnt_r <= launch_lat_s;
            end else if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // HI/LO architectural registers: completion write-back or mthi/mtlo move.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (result_we_s) begin
            hi_r <= result_s[63:32];
            lo_r <= result_s[31:0];
        end else if (write_hi_s) begin
            hi_r <= A;
        end else if (write_lo_s) begin
            lo_r <= A;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. Inputs are driven and outputs sampled
// on the falling edge. Every launched operation pushes its expected {HI,LO}
// onto a scoreboard queue, popped and compared when busy falls.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDUcal;
    logic [3:0]  MDUwrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MDUcal   (MDUcal),
        .MDUwrite (MDUwrite),
        .A        (A),
        .B        (B),
        .Req      (Req),
        .busy     (busy),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {HI,LO} after the operation.
    function automatic logic [63:0] model_result(input logic [3:0]  cal,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input logic [31:0] old_hi,
                                                 input logic [31:0] old_lo);
        int              sa;
        int              sb;
        longint          p;
        longint unsigned up;
        sa = a;
        sb = b;
        case (cal)
            4'd1: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            4'd2: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            4'd3: begin
                if (sb == 0) return {old_hi, old_lo};
                return {sa % sb, sa / sb};
            end
            4'd4: begin
                if (b == 32'd0) return {old_hi, old_lo};
                return {a % b, a / b};
            end
            default: return {old_hi, old_lo};
        endcase
    endfunction

    // Launch one operation at the current falling edge and check it to completion.
    task automatic run_op(input string name, input logic [3:0] cal,
                          input logic [31:0] a, input logic [31:0] b);
        int          n;
        int          lat;
        logic [63:0] e;
        A = a; B = b; MDUcal = cal; start = 1'b1; Req = 1'b0;
        e = model_result(cal, a, b, model_hi, model_lo);
        exp_q.push_back(e);
        model_hi = e[63:32];
        model_lo = e[31:0];
        lat = (cal <= 4'd2) ? 5 : 10;
        @(negedge clk);
        start = 1'b0; MDUwrite = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, lat);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", name);
        end else begin
            e = exp_q.pop_front();
            if ({HI, LO} !== e) begin
                errors++;
                $display("FAIL %s hi_lo: got %h_%h expected %h_%h", name, HI, LO, e[63:32], e[31:0]);
            end
        end
    endtask

    // mthi/mtlo move at the current falling edge, optionally masked by Req.
    task automatic move(input string name, input logic [3:0] wr,
                        input logic [31:0] v, input logic req);
        MDUwrite = wr; A = v; Req = req; start = 1'b0;
        if (!req && wr == 4'd1) model_hi = v;
        if (!req && wr == 4'd2) model_lo = v;
        @(negedge clk);
        MDUwrite = 4'd0; Req = 1'b0;
        checks++;
        if (HI !== model_hi || LO !== model_lo) begin
            errors++;
            $display("FAIL %s: got %h_%h expected %h_%h", name, HI, LO, model_hi, model_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; MDUcal = 4'd1; MDUwrite = 4'd1;
        A = 32'hDEAD_BEEF; B = 32'd3; Req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h expected 0 0 0", busy, HI, LO);
        end
        start = 1'b0; MDUwrite = 4'd0; reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_mult();
        run_op("sign_mult", 4'd1, 32'hFFFF_FFFF, 32'd2);
        run_op("zero_mult", 4'd2, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL zero_mult_const: got %h_%h expected 00000001_fffffffe", HI, LO);
        end
    endtask

    task automatic test_div();
        run_op("sign_div", 4'd3, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL sign_div_const: got %h_%h expected ffffffff_fffffffd", HI, LO);
        end
        run_op("zero_div", 4'd4, 32'hFFFF_FFF9, 32'd2);
    endtask

    task automatic test_div_zero();
        move("preload_hi", 4'd1, 32'h11, 1'b0);
        move("preload_lo", 4'd2, 32'h22, 1'b0);
        run_op("divu_by_zero", 4'd4, 32'd5, 32'd0);
        run_op("div_by_zero", 4'd3, 32'hFFFF_FFF0, 32'd0);
        checks++;
        if (HI !== 32'h11 || LO !== 32'h22) begin
            errors++;
            $display("FAIL div_zero_const: got %h_%h expected 00000011_00000022", HI, LO);
        end
    endtask

    task automatic test_req_mask();
        move("mthi_req_masked", 4'd1, 32'h1234_5678, 1'b1);
        move("mthi_req_clear", 4'd1, 32'h1234_5678, 1'b0);
        move("mtlo_req_masked", 4'd2, 32'hCAFE_F00D, 1'b1);
        move("mtlo_req_clear", 4'd2, 32'hCAFE_F00D, 1'b0);
        A = 32'd9; B = 32'd9; MDUcal = 4'd1; start = 1'b1; Req = 1'b1;
        @(negedge clk);
        start = 1'b0; Req = 1'b0;
        checks++;
        if (busy !== 1'b0 || HI !== model_hi || LO !== model_lo) begin
            errors++;
            $display("FAIL start_req_masked: got busy=%b %h_%h expected 0 %h_%h", busy, HI, LO, model_hi, model_lo);
        end
    endtask

    task automatic test_illegal_cal();
        logic [3:0] bad[3];
        bad[0] = 4'd0; bad[1] = 4'd5; bad[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            A = 32'd7; B = 32'd3; MDUcal = bad[i]; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (busy !== 1'b0 || HI !== model_hi || LO !== model_lo) begin
                errors++;
                $display("FAIL illegal_cal_%0d: got busy=%b %h_%h expected 0 %h_%h", bad[i], busy, HI, LO, model_hi, model_lo);
            end
        end
    endtask

    task automatic test_start_wins();
        MDUwrite = 4'd1;
        run_op("start_wins", 4'd2, 32'd7, 32'd6);
    endtask

    task automatic test_busy_ignore();
        int          n;
        logic [63:0] e;
        A = 32'd3; B = 32'd4; MDUcal = 4'd2; start = 1'b1;
        e = model_result(4'd2, 32'd3, 32'd4, model_hi, model_lo);
        exp_q.push_back(e);
        model_hi = e[63:32];
        model_lo = e[31:0];
        @(negedge clk);
        A = 32'd100; B = 32'd7; MDUcal = 4'd3; MDUwrite = 4'd2;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 3) begin
                start = 1'b0; MDUwrite = 4'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; MDUwrite = 4'd0;
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL busy_ignore_cycles: got %0d expected 5", n);
        end
        checks++;
        e = exp_q.pop_front();
        if ({HI, LO} !== e) begin
            errors++;
            $display("FAIL busy_ignore_hi_lo: got %h_%h expected %h_%h", HI, LO, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_0", 4'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("b2b_1", 4'd3, 32'd100, 32'hFFFF_FFF9);
        run_op("b2b_2", 4'd4, 32'hFFFF_FFFF, 32'd10);
        run_op("b2b_3", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [3:0]  cal;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            cal = 4'($urandom_range(1, 4));
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (cal == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            run_op("random", cal, a, b);
        end
    endtask

    task automatic test_reset_mid_op();
        A = 32'hFFFF_FFFF; B = 32'd2; MDUcal = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_op_busy: got busy=%b expected 1", busy);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_hi = 32'd0;
        model_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL mid_op_reset: got busy=%b %h_%h expected 0 0_0", busy, HI, LO);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL mid_op_no_writeback: got busy=%b %h_%h expected 0 0_0", busy, HI, LO);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; MDUcal = 4'd0; MDUwrite = 4'd0;
        A = 32'd0; B = 32'd0; Req = 1'b0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_req_mask();
        test_illegal_cal();
        test_start_wins();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
